// File: rtl/seg_scan_pkg.sv
// Shared definitions for the 7-segment scan controller: FSM encoding,
// blank segment pattern and an all-anodes-off mask helper.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_e;

    // Active-low segments g..a, all dark.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Widest anode vector the helper below can describe.
    localparam int AN_MAX_W = 32;

    // Active-low anodes: returns a mask with the low n bits set (all off).
    function automatic logic [AN_MAX_W-1:0] an_off(input int n);
        logic [AN_MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < AN_MAX_W; i++) begin
            if (i < n) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Digit bus from the counter datapath and display pin bundle of the scan
// controller. The controller uses the slave view; the producer of digits
// and consumer of pins uses the master view.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8
);
    logic                      en;
    logic [4*NUM_DIGITS-1:0]   digits;
    logic [NUM_DIGITS-1:0]     dp_mask;
    logic                      lz_suppress;
    logic [6:0]                seg;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_start;

    modport master (
        output en, digits, dp_mask, lz_suppress,
        input  seg, dp, an, frame_start
    );

    modport slave (
        input  en, digits, dp_mask, lz_suppress,
        output seg, dp, an, frame_start
    );
endinterface

// File: rtl/bcd_to_7seg.sv
// Shared BCD to 7-segment decoder, active-low segments g..a.
// Codes above 9 show the "0" pattern.
module bcd_to_7seg (
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    // Pure lookup, one pattern per BCD code.
    always_comb begin
        case (bcd)
            4'd0:    seg_n = 7'h40;
            4'd1:    seg_n = 7'h79;
            4'd2:    seg_n = 7'h24;
            4'd3:    seg_n = 7'h30;
            4'd4:    seg_n = 7'h19;
            4'd5:    seg_n = 7'h12;
            4'd6:    seg_n = 7'h02;
            4'd7:    seg_n = 7'h78;
            4'd8:    seg_n = 7'h00;
            4'd9:    seg_n = 7'h10;
            default: seg_n = 7'h40;
        endcase
    end

endmodule

// File: rtl/digit_slot_timer.sv
// Slot counter for the scan controller. Counts clock cycles inside the
// current BLANK or DRIVE phase and flags the last cycle of each phase.
// The owner clears it on every phase change and while idle.
module digit_slot_timer #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic blank_tc,
    output logic drive_tc
);

    localparam int CW = $clog2(SCAN_DIV);

    // Last count value of each phase; DRIVE fills the rest of the slot.
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - BLANK_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Restart at zero on a phase change, otherwise count up.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal counts are decoded from the registered count so the FSM
    // next-state logic has no combinational loop through the clear.
    assign blank_tc = (cnt_q == BLANK_LAST);
    assign drive_tc = (cnt_q == DRIVE_LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed driver for a common-anode multi-digit 7-segment display.
// Each digit slot starts with a dark guard interval (BLANK) before the
// anode is enabled (DRIVE), so the old digit's segments never appear under
// the new anode. Inputs are snapshotted once per frame so a digit bus that
// changes mid-scan cannot tear the displayed value.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    seg_scan_ctrl_if.slave  bus
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = NUM_DIGITS'(an_off(NUM_DIGITS));

    state_e                    state_q;
    state_e                    state_d;
    logic [IW-1:0]             idx_q;
    logic [IW-1:0]             idx_d;

    logic [4*NUM_DIGITS-1:0]   digits_snap_q;
    logic [4*NUM_DIGITS-1:0]   digits_snap_d;
    logic [NUM_DIGITS-1:0]     dp_mask_snap_q;
    logic [NUM_DIGITS-1:0]     dp_mask_snap_d;
    logic                      lz_snap_q;
    logic                      lz_snap_d;

    logic [NUM_DIGITS-1:0]     an_q;
    logic [NUM_DIGITS-1:0]     an_d;
    logic [6:0]                seg_q;
    logic [6:0]                seg_d;
    logic                      dp_q;
    logic                      dp_d;
    logic                      frame_start_q;
    logic                      frame_start_d;

    logic                      take_snap;
    logic                      clr;
    logic                      blank_tc;
    logic                      drive_tc;
    logic [NUM_DIGITS-1:0]     lz_blank;
    logic [3:0]                sel_digit;
    logic [6:0]                dec_seg;

    digit_slot_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .blank_tc (blank_tc),
        .drive_tc (drive_tc)
    );

    // Next-state logic: phase sequencing, digit index and snapshot strobe.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        take_snap = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.en) begin
                    state_d   = ST_BLANK;
                    take_snap = 1'b1;
                end
            end
            ST_BLANK: begin
                if (!bus.en) begin
                    state_d = ST_IDLE;
                end else if (blank_tc) begin
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (!bus.en) begin
                    state_d = ST_IDLE;
                end else if (drive_tc) begin
                    state_d = ST_BLANK;
                    if (idx_q == IDX_LAST) begin
                        idx_d     = '0;
                        take_snap = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Re-enabling always starts a fresh frame at the rightmost digit.
        if (state_d == ST_IDLE) begin
            idx_d = '0;
        end
        clr = (state_d != state_q) || (state_d == ST_IDLE);

        digits_snap_d  = digits_snap_q;
        dp_mask_snap_d = dp_mask_snap_q;
        lz_snap_d      = lz_snap_q;
        if (take_snap) begin
            digits_snap_d  = bus.digits;
            dp_mask_snap_d = bus.dp_mask;
            lz_snap_d      = bus.lz_suppress;
        end
    end

    // Leading-zero mask: a digit is dark when it and everything to its
    // left are zero. Digit 0 always shows so a zero value reads "0".
    always_comb begin
        logic zero_run;
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run    = zero_run & (digits_snap_d_unused_guard(i) == 4'd0);
            lz_blank[i] = zero_run & lz_snap_q;
        end
    end

    // Picks digit i out of the current snapshot.
    function automatic logic [3:0] digits_snap_d_unused_guard(input int i);
        return digits_snap_q[4*i +: 4];
    endfunction

    assign sel_digit = digits_snap_q[{idx_q, 2'b00} +: 4];

    bcd_to_7seg u_dec (
        .bcd   (sel_digit),
        .seg_n (dec_seg)
    );

    // Output decode from the current state; registered below so pins
    // change one cycle after each state transition, glitch-free.
    always_comb begin
        an_d          = AN_ALL_OFF;
        seg_d         = SEG_BLANK;
        dp_d          = 1'b1;
        frame_start_d = take_snap;
        if (state_q == ST_DRIVE) begin
            an_d[idx_q] = 1'b0;
            seg_d       = lz_blank[idx_q] ? SEG_BLANK : dec_seg;
            dp_d        = ~dp_mask_snap_q[idx_q];
        end
    end

    // Control and pin registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            an_q          <= AN_ALL_OFF;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Frame snapshot registers; contents are only used after a capture.
    always_ff @(posedge clk) begin
        digits_snap_q  <= digits_snap_d;
        dp_mask_snap_q <= dp_mask_snap_d;
        lz_snap_q      <= lz_snap_d;
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.frame_start = frame_start_q;

endmodule
